ram2_program_loader: RTL and testbench

//  Write-side companion to the RAM2 instruction fetch path: streams 16-bit instruction words

---
 rtl/ram2_program_loader_pkg.sv | 15 +
 rtl/ram2_write_strobe.sv | 59 +++++
 rtl/ram2_program_loader.sv | 119 +++++++++++
 tb/tb_ram2_program_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram2_program_loader_pkg.sv
// Shared definitions for the RAM2 program loader: bus widths and state encodings.
package ram2_program_loader_pkg;

  localparam int ADDR_W  = 18;
  localparam int WORD_W  = 16;
  localparam int COUNT_W = 17;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/ram2_write_strobe.sv
// One RAM2 write cycle: a SETUP cycle, WE_CYCLES cycles of WE low, then one HOLD cycle.
module ram2_write_strobe
  import ram2_program_loader_pkg::*;
#(
  parameter int WE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic go_i,
  output logic we_n_o,
  output logic drive_o,
  output logic wr_done_o
);

  localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  logic [2:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_n_q;
  logic          drive_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      S_IDLE:  if (go_i) phase_d = S_SETUP;
      S_SETUP: begin
        phase_d = S_WRITE;
        cnt_d   = CW'(WE_CYCLES - 1);
      end
      S_WRITE: begin
        if (cnt_q == '0) phase_d = S_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_HOLD:  phase_d = S_IDLE;
      default: phase_d = S_IDLE;
    endcase
  end

  // WE and data-enable are flopped from the next phase so the pins never glitch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= S_IDLE;
      cnt_q   <= '0;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      we_n_q  <= (phase_d != S_WRITE);
      drive_q <= (phase_d != S_IDLE);
    end
  end

  assign we_n_o    = we_n_q;
  assign drive_o   = drive_q;
  assign wr_done_o = (phase_q == S_HOLD);

endmodule

// File: rtl/ram2_program_loader.sv
// Streams NUM_WORDS instruction words from a valid/ready source into external RAM2
// starting at START_ADDR, owning the RAM2 pins only while a load is in progress.
module ram2_program_loader
  import ram2_program_loader_pkg::*;
#(
  parameter int                NUM_WORDS  = 512,
  parameter logic [ADDR_W-1:0] START_ADDR = 18'h0,
  parameter int                WE_CYCLES  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bus_own,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_done,
  output logic              RAM2OE,
  output logic              RAM2WE,
  output logic              RAM2EN,
  output logic [ADDR_W-1:0] RAM2ADDR,
  inout  wire  [WORD_W-1:0] RAM2DATA
);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(NUM_WORDS);

  logic [2:0]         state_q, state_d;
  logic [COUNT_W-1:0] words_q, words_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               in_ready_q, bus_own_q, busy_q, done_q, en_n_q;
  logic               accept, active_d;
  logic               we_n, drive, wr_done;

  assign accept = (state_q == S_LOAD) && in_valid && in_ready_q;

  // The loader sits in S_SETUP for the whole strobe sequence; the strobe
  // sub-module tracks the SETUP/WRITE/HOLD phases and flags HOLD via wr_done.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          words_d = '0;
          addr_d  = START_ADDR;
        end
      end
      S_LOAD: begin
        if (accept) begin
          data_d  = in_data;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (wr_done) begin
          words_d = words_q + COUNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (words_d == LAST_COUNT) ? S_DONE : S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign active_d = (state_d == S_LOAD) || (state_d == S_SETUP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      words_q    <= '0;
      addr_q     <= START_ADDR;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      bus_own_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= (state_d == S_LOAD);
      bus_own_q  <= active_d;
      busy_q     <= active_d;
      done_q     <= (state_d == S_DONE);
      en_n_q     <= !active_d;
    end
  end

  ram2_write_strobe #(
    .WE_CYCLES (WE_CYCLES)
  ) u_strobe (
    .clk_i     (CLK),
    .rst_i     (RST),
    .go_i      (accept),
    .we_n_o    (we_n),
    .drive_o   (drive),
    .wr_done_o (wr_done)
  );

  assign in_ready   = in_ready_q;
  assign bus_own    = bus_own_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = words_q[15:0];
  assign RAM2OE     = 1'b1;
  assign RAM2WE     = we_n;
  assign RAM2EN     = en_n_q;
  assign RAM2ADDR   = addr_q;
  assign RAM2DATA   = drive ? data_q : 'z;

endmodule

// File: tb/tb_ram2_program_loader.sv
// Randomized bench for ram2_program_loader: per-cycle reference model plus a RAM2 pin monitor.
module tb_ram2_program_loader;

  localparam int          NW = 4;
  localparam logic [17:0] SA = 18'h3FFFE;
  localparam int          WC = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready, bus_own, busy, done;
  logic [15:0] words_done;
  logic        RAM2OE, RAM2WE, RAM2EN;
  logic [17:0] RAM2ADDR;
  wire  [15:0] RAM2DATA;

  // Undriven data bus reads back as all ones, so stimulus never uses 16'hFFFF.
  pullup (RAM2DATA);

  ram2_program_loader #(
    .NUM_WORDS  (NW),
    .START_ADDR (SA),
    .WE_CYCLES  (WC)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bus_own    (bus_own),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .RAM2OE     (RAM2OE),
    .RAM2WE     (RAM2WE),
    .RAM2EN     (RAM2EN),
    .RAM2ADDR   (RAM2ADDR),
    .RAM2DATA   (RAM2DATA)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. mode: 0 idle, 1 waiting for a word, 2 writing, 3 done.
  // While writing, k counts cycles since the word was accepted:
  // k=0 setup, k=1..WC write strobe low, k=WC+1 hold.
  int          m_mode = 0;
  int          m_k = 0;
  int          m_words = 0;
  logic [17:0] m_addr = 18'h0;
  logic [15:0] m_data = 16'h0;
  bit          m_valid = 1'b0;
  logic [15:0] exp_slot [NW];
  logic [15:0] sram_slot [NW];
  int          we_run = 0;

  always @(posedge CLK) begin
    int          mode_n, k_n, words_n;
    logic [17:0] addr_n;
    logic [15:0] data_n;
    mode_n  = m_mode;
    k_n     = m_k;
    words_n = m_words;
    addr_n  = m_addr;
    data_n  = m_data;
    if (RST) begin
      mode_n  = 0;
      k_n     = 0;
      words_n = 0;
    end else begin
      case (m_mode)
        0, 3: if (start) begin
          mode_n  = 1;
          words_n = 0;
          addr_n  = SA;
        end
        1: if (in_valid) begin
          data_n = in_data;
          mode_n = 2;
          k_n    = 0;
        end
        2: if (m_k == WC + 1) begin
          exp_slot[m_words] <= m_data;
          words_n = m_words + 1;
          addr_n  = m_addr + 18'd1;
          mode_n  = (words_n == NW) ? 3 : 1;
        end else begin
          k_n = m_k + 1;
        end
        default: mode_n = 0;
      endcase
    end
    m_mode  <= mode_n;
    m_k     <= k_n;
    m_words <= words_n;
    m_addr  <= addr_n;
    m_data  <= data_n;
    m_valid <= m_valid | RST;
  end

  // Compare every output each cycle, and record writes seen on the pins.
  always @(negedge CLK) begin
    if (m_valid) begin
      bit          act, we_low;
      logic [17:0] off;
      act    = (m_mode == 1) || (m_mode == 2);
      we_low = (m_mode == 2) && (m_k >= 1) && (m_k <= WC);
      check("in_ready", in_ready, m_mode == 1);
      check("bus_own", bus_own, act);
      check("busy", busy, act);
      check("done", done, m_mode == 3);
      check("words_done", words_done, m_words[15:0]);
      check("ram2oe", RAM2OE, 1);
      check("ram2en", RAM2EN, !act);
      check("ram2we", RAM2WE, !we_low);
      check("ram2data", RAM2DATA, (m_mode == 2) ? m_data : 16'hFFFF);
      if (act) check("ram2addr", RAM2ADDR, m_addr);
      if (RST) begin
        we_run <= 0;
      end else if (RAM2WE == 1'b0) begin
        off = RAM2ADDR - SA;
        check("wr_addr_range", off < 18'(NW), 1);
        if (off < 18'(NW)) sram_slot[off[1:0]] <= RAM2DATA;
        we_run <= we_run + 1;
      end else if (we_run > 0) begin
        check("we_low_len", we_run, WC);
        we_run <= 0;
      end
    end
  end

  task automatic send_word(input logic [15:0] d, input int stall);
    in_valid = 1'b0;
    repeat (stall) @(negedge CLK);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        @(negedge CLK);
        in_valid = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) return;
      @(negedge CLK);
    end
    check("done_timeout", 0, 1);
  endtask

  function automatic logic [15:0] rand_word();
    return 16'($urandom_range(0, 32'hFFFE));
  endfunction

  task automatic check_slots(input string name);
    for (int i = 0; i < NW; i++) check(name, sram_slot[i], exp_slot[i]);
  endtask

  initial begin
    // Reset held three cycles.
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_we", RAM2WE, 1);
    check("rst_oe", RAM2OE, 1);
    check("rst_en", RAM2EN, 1);
    check("rst_data_z", RAM2DATA, 16'hFFFF);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Back-to-back stream of fixed words; addresses wrap through 3FFFF.
    pulse_start();
    for (int i = 0; i < NW; i++) send_word(16'h1111 * 16'(i + 1), 0);
    wait_done();
    check("t2_done", done, 1);
    check("t2_words_done", words_done, 4);
    check("t2_bus_own", bus_own, 0);
    check("t2_mem_3fffe", sram_slot[0], 16'h1111);
    check("t2_mem_3ffff", sram_slot[1], 16'h2222);
    check("t2_mem_00000", sram_slot[2], 16'h3333);
    check("t2_mem_00001", sram_slot[3], 16'h4444);

    // Five-cycle source stalls, with a start pulse mid-load that must be ignored.
    pulse_start();
    check("t6_done_cleared", done, 0);
    check("t6_words_cleared", words_done, 0);
    for (int i = 0; i < NW; i++) begin
      send_word(rand_word(), 5);
      if (i == 1) pulse_start();
    end
    wait_done();
    check("t3_done", done, 1);
    check_slots("t3_mem");

    // Reset during the strobe of word 2 aborts immediately.
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(rand_word(), 0);
    for (int i = 0; i < 20 && RAM2WE; i++) @(negedge CLK);
    check("t5_saw_we_low", RAM2WE, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("t5_we", RAM2WE, 1);
    check("t5_data_z", RAM2DATA, 16'hFFFF);
    check("t5_en", RAM2EN, 1);
    check("t5_in_ready", in_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_words_done", words_done, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Randomized reloads overwriting from the start address.
    for (int n = 0; n < 6; n++) begin
      pulse_start();
      for (int i = 0; i < NW; i++) begin
        send_word(rand_word(), int'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) pulse_start();
      end
      wait_done();
      check("rand_done", done, 1);
      check_slots("rand_mem");
      repeat ($urandom_range(0, 4)) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
